// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and its picker.
package wb_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping modulo N.
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] next_idx_o,
  output logic          valid_o
);

  // Scan from the farthest candidate down to the nearest so the nearest one wins.
  always_comb begin
    int cand;
    cand       = 0;
    valid_o    = 1'b0;
    next_idx_o = '0;
    for (int off = N; off >= 1; off--) begin
      cand = int'(last_i) + off;
      if (cand >= N) cand = cand - N;
      if (req_i[IW'(cand)]) begin
        valid_o    = 1'b1;
        next_idx_o = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters, grant locked per cycle.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS-1:0]            m_strobe,
  input  logic [NUM_MASTERS-1:0]            m_cycle,
  output logic [DATA_WIDTH-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_grant,
  output logic [ADDR_WIDTH-1:0]             wbs_address,
  output logic [DATA_WIDTH-1:0]             wbs_writedata,
  output logic                              wbs_write,
  output logic                              wbs_strobe,
  output logic                              wbs_cycle,
  input  logic [DATA_WIDTH-1:0]             wbs_readdata,
  input  logic                              wbs_ack,
`ifdef WB_ARB_TIMEOUT_EN
  output logic                              timeout_err,
`endif
  output logic                              dbg_state_o
);

  localparam int IW = clog2_min1(NUM_MASTERS);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          sel_cycle;
  logic          timeout_hit;

  wb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i      (m_cycle),
    .last_i     (last_grant_q),
    .next_idx_o (pick_idx),
    .valid_o    (pick_valid)
  );

  assign sel_cycle   = (state_q == ST_BUSY) && m_cycle[grant_idx_q];
  assign dbg_state_o = logic'(state_q);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = clog2_min1(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = wbs_strobe && !wbs_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_hit;

  // Counter idles at zero outside BUSY, so every new grant starts a fresh window.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_BUSY || wbs_ack || timeout_hit) begin
      cnt_d = '0;
    end else if (wbs_strobe) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    last_grant_d  = last_grant_q;
    m_grant       = '0;
    m_ack         = '0;
    m_readdata    = '0;
    wbs_cycle     = 1'b0;
    wbs_strobe    = 1'b0;
    wbs_write     = 1'b0;
    wbs_address   = '0;
    wbs_writedata = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_idx_d = pick_idx;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        m_grant[grant_idx_q] = 1'b1;
        wbs_cycle  = sel_cycle;
        wbs_strobe = sel_cycle && m_strobe[grant_idx_q];
        wbs_write  = sel_cycle && m_write[grant_idx_q];
        if (sel_cycle) begin
          wbs_address   = m_address[int'(grant_idx_q)*ADDR_WIDTH +: ADDR_WIDTH];
          wbs_writedata = m_writedata[int'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH];
        end
        m_readdata           = wbs_readdata;
        // An ack without a live strobe belongs to no transfer and is dropped.
        m_ack[grant_idx_q]   = wbs_ack && wbs_strobe;
        if (timeout_hit) begin
          m_ack[grant_idx_q] = 1'b1;
          m_readdata         = '1;
        end
        if (!sel_cycle || timeout_hit) begin
          last_grant_d = grant_idx_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: vector table, grant-order scoreboard, corner sequences.
module tb_wb_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m_address;
  logic [31:0] m_writedata;
  logic [1:0]  m_write, m_strobe, m_cycle;
  logic [15:0] m_readdata;
  logic [1:0]  m_ack, m_grant;
  logic [15:0] wbs_address, wbs_writedata;
  logic        wbs_write, wbs_strobe, wbs_cycle;
  logic [15:0] wbs_readdata;
  logic        wbs_ack;
  logic        dbg_state;
`ifdef WB_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  logic [1:0] prev_grant;
  logic       mon_en;

  wb_rr_arbiter #(
    .NUM_MASTERS    (2),
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_write       (m_write),
    .m_strobe      (m_strobe),
    .m_cycle       (m_cycle),
    .m_readdata    (m_readdata),
    .m_ack         (m_ack),
    .m_grant       (m_grant),
    .wbs_address   (wbs_address),
    .wbs_writedata (wbs_writedata),
    .wbs_write     (wbs_write),
    .wbs_strobe    (wbs_strobe),
    .wbs_cycle     (wbs_cycle),
    .wbs_readdata  (wbs_readdata),
    .wbs_ack       (wbs_ack),
`ifdef WB_ARB_TIMEOUT_EN
    .timeout_err   (timeout_err),
`endif
    .dbg_state_o   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic [1:0] cyc, input logic [1:0] stb, input logic [1:0] we,
                       input logic ack, input logic [15:0] rd);
    m_cycle      = cyc;
    m_strobe     = stb;
    m_write      = we;
    wbs_ack      = ack;
    wbs_readdata = rd;
  endtask

  task automatic wait_grant(input int idx, input int budget);
    logic found;
    found = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (m_grant[idx]) begin
        found = 1'b1;
        break;
      end
    end
    chk($sformatf("grant_wait_m%0d", idx), {31'd0, found}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 1'b0, 16'h0000);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard monitor: grant order, turnaround gap, one-hot grant, ack routing.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_grant != 2'b00 && prev_grant == 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", {30'd0, m_grant}, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("grant_order", {30'd0, m_grant}, {30'd0, 2'(32'd1 << e)});
        end
      end
      if (m_grant != 2'b00 && prev_grant != 2'b00 && m_grant != prev_grant)
        chk("turnaround_gap", {30'd0, prev_grant}, 32'd0);
      if ($countones(m_grant) > 1)
        chk("grant_onehot", {30'd0, m_grant}, 32'd1);
      if ((m_ack & ~m_grant) != 2'b00)
        chk("stray_ack", {30'd0, m_ack & ~m_grant}, 32'd0);
      prev_grant <= m_grant;
    end
  end

  typedef struct {
    logic [1:0]  cyc, stb, we;
    logic        ack;
    logic [15:0] rd;
    logic [1:0]  e_grant;
    logic        e_cyc, e_stb, e_we;
    logic [15:0] e_addr, e_wdata;
    logic [1:0]  e_ack;
    logic        chk_rd;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int         rem[2];
    logic       cool[2];
    logic       ack_next;
    logic [15:0] rd_val;

    vecs[0]  = '{2'b00, 2'b00, 2'b00, 1'b1, 16'hBEEF, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vecs[1]  = '{2'b01, 2'b01, 2'b01, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vecs[2]  = '{2'b01, 2'b01, 2'b01, 1'b0, 16'h1111, 2'b01, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hA5A5, 2'b00, 1'b1, 16'h1111};
    vecs[3]  = '{2'b01, 2'b01, 2'b01, 1'b1, 16'h2222, 2'b01, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hA5A5, 2'b01, 1'b1, 16'h2222};
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 1'b0, 16'h3333, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h3333};
    vecs[5]  = '{2'b11, 2'b11, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vecs[6]  = '{2'b11, 2'b11, 2'b10, 1'b1, 16'h4444, 2'b10, 1'b1, 1'b1, 1'b1, 16'h0222, 16'h1234, 2'b10, 1'b1, 16'h4444};
    vecs[7]  = '{2'b01, 2'b01, 2'b00, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000};
    vecs[8]  = '{2'b01, 2'b01, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000};
    vecs[9]  = '{2'b01, 2'b01, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b1, 1'b0, 16'h0010, 16'hA5A5, 2'b00, 1'b1, 16'h0000};
    vecs[10] = '{2'b01, 2'b00, 2'b00, 1'b1, 16'h5555, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0010, 16'hA5A5, 2'b00, 1'b1, 16'h5555};
    vecs[11] = '{2'b00, 2'b00, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000};

    mon_en      = 1'b0;
    prev_grant  = 2'b00;
    reset       = 1'b0;
    m_address   = {16'h0222, 16'h0010};
    m_writedata = {16'h1234, 16'hA5A5};
    drive(2'b00, 2'b00, 2'b00, 1'b0, 16'h0000);

    #3;
    chk("reset_grant", {30'd0, m_grant}, 32'd0);
    chk("reset_wbs_cycle", {31'd0, wbs_cycle}, 32'd0);
    chk("reset_state", {31'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Vector table: single write, tie, early drop, strobe-less ack.
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].ack, vecs[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), {30'd0, m_grant}, {30'd0, vecs[i].e_grant});
      chk($sformatf("v%0d_wbs_cycle", i), {31'd0, wbs_cycle}, {31'd0, vecs[i].e_cyc});
      chk($sformatf("v%0d_wbs_strobe", i), {31'd0, wbs_strobe}, {31'd0, vecs[i].e_stb});
      chk($sformatf("v%0d_wbs_write", i), {31'd0, wbs_write}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_wbs_address", i), {16'd0, wbs_address}, {16'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_wbs_writedata", i), {16'd0, wbs_writedata}, {16'd0, vecs[i].e_wdata});
      chk($sformatf("v%0d_m_ack", i), {30'd0, m_ack}, {30'd0, vecs[i].e_ack});
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_m_readdata", i), {16'd0, m_readdata}, {16'd0, vecs[i].e_rd});
    end

    // Both masters keep requesting, three single accesses each: strict alternation.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd1);
    end
    rem[0] = 3; rem[1] = 3;
    cool[0] = 1'b0; cool[1] = 1'b0;
    ack_next = 1'b0;
    rd_val = 16'h0000;
    for (int c = 0; c < 200; c++) begin
      if (rem[0] == 0 && rem[1] == 0) break;
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        m_cycle[m]  = (rem[m] > 0) && !cool[m];
        m_strobe[m] = m_cycle[m];
        cool[m]     = 1'b0;
      end
      m_write      = 2'b10;
      wbs_ack      = ack_next;
      rd_val       = 16'($urandom_range(0, 16'hFFFF));
      wbs_readdata = rd_val;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (m_ack[m]) begin
          chk($sformatf("rr_readdata_m%0d", m), {16'd0, m_readdata}, {16'd0, rd_val});
          rem[m]--;
          cool[m] = 1'b1;
        end
      end
      ack_next = wbs_strobe && !wbs_ack;
    end
    chk("rr_accesses_left", rem[0] + rem[1], 32'd0);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 16'h0000);

    // Master 1 holds the bus through a 5-cycle stall while master 0 waits.
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    @(posedge clk); #1;
    drive(2'b10, 2'b10, 2'b00, 1'b0, 16'h0000);
    wait_grant(1, 4);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      drive(2'b11, 2'b11, 2'b00, 1'b0, 16'h0000);
      @(negedge clk);
      chk($sformatf("stall%0d_m_ack", s), {30'd0, m_ack}, 32'd0);
      chk($sformatf("stall%0d_grant", s), {30'd0, m_grant}, 32'd2);
    end
    @(posedge clk); #1;
    drive(2'b11, 2'b11, 2'b00, 1'b1, 16'h6789);
    @(negedge clk);
    chk("stall_end_m_ack", {30'd0, m_ack}, 32'd2);
    @(posedge clk); #1;
    drive(2'b01, 2'b01, 2'b00, 1'b0, 16'h0000);
    @(negedge clk);
    chk("stall_release_m_ack", {30'd0, m_ack}, 32'd0);
    wait_grant(0, 4);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 16'h0000);

    // Asynchronous reset in the middle of a strobed cycle.
    exp_q.push_back(8'd1);
    @(posedge clk); #1;
    drive(2'b10, 2'b10, 2'b10, 1'b0, 16'hCAFE);
    wait_grant(1, 4);
    chk("pre_reset_strobe", {31'd0, wbs_strobe}, 32'd1);
    #2;
    wbs_ack = 1'b1;
    reset   = 1'b0;
    #1;
    chk("async_grant", {30'd0, m_grant}, 32'd0);
    chk("async_wbs_cycle", {31'd0, wbs_cycle}, 32'd0);
    chk("async_wbs_strobe", {31'd0, wbs_strobe}, 32'd0);
    chk("async_wbs_write", {31'd0, wbs_write}, 32'd0);
    chk("async_wbs_address", {16'd0, wbs_address}, 32'd0);
    chk("async_m_ack", {30'd0, m_ack}, 32'd0);
    chk("async_m_readdata", {16'd0, m_readdata}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back(8'd0);
    drive(2'b11, 2'b11, 2'b00, 1'b0, 16'h0000);
    reset = 1'b1;
    wait_grant(0, 4);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 16'h0000);

    // Granted master abandons the cycle, then the slave acks late.
    exp_q.push_back(8'd0);
    @(posedge clk); #1;
    drive(2'b01, 2'b01, 2'b00, 1'b0, 16'h0000);
    wait_grant(0, 4);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 2'b00, 1'b1, 16'h7777);
    @(negedge clk);
    chk("drop_m_ack", {30'd0, m_ack}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("late_ack_m_ack", {30'd0, m_ack}, 32'd0);
    chk("late_ack_grant", {30'd0, m_grant}, 32'd0);
    chk("late_ack_state", {31'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 16'h0000);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: watchdog completes the transfer on the 8th stalled cycle.
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd0);
    @(posedge clk); #1;
    drive(2'b01, 2'b01, 2'b00, 1'b0, 16'h1234);
    wait_grant(0, 4);
    for (int s = 1; s <= 8; s++) begin
      if (s > 1) @(negedge clk);
      if (s < 8) begin
        chk($sformatf("wd%0d_m_ack", s), {30'd0, m_ack}, 32'd0);
        chk($sformatf("wd%0d_timeout_err", s), {31'd0, timeout_err}, 32'd0);
      end else begin
        chk("wd_m_ack", {30'd0, m_ack}, 32'd1);
        chk("wd_m_readdata", {16'd0, m_readdata}, 32'h0000FFFF);
        chk("wd_timeout_err", {31'd0, timeout_err}, 32'd1);
      end
    end
    @(negedge clk);
    chk("wd_after_grant", {30'd0, m_grant}, 32'd0);
    chk("wd_after_wbs_cycle", {31'd0, wbs_cycle}, 32'd0);
    chk("wd_after_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 2'b00, 1'b0, 16'h0000);
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
